// File: rtl/alu_pkg.sv
// Shared definitions for the bit-serial ALU controller and its 1-bit cell.
// Holds the op-code constants that select the cell function and the
// encoding of the controller FSM states.
package alu_pkg;

  // Op codes, as presented on sel and captured on an accepted start
  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_AND = 2'b10;
  localparam logic [1:0] OP_OR  = 2'b11;

  // Controller FSM states
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_t;

  // True for the bitwise op codes, which never produce a carry
  function automatic logic is_logic_op(input logic [1:0] op);
    return (op == OP_AND) || (op == OP_OR);
  endfunction

endpackage

// File: rtl/alu_serial_ctrl_alu.sv
// 1-bit ALU cell (module alu) used by alu_serial_ctrl.
// Ports:
//   i0, i1 : operand bits
//   s      : op code (alu_pkg OP_*)
//   cIn    : carry in
//   res    : result bit
//   cOut   : carry out (always 0 for AND/OR)
// Subtraction is done as i0 + ~i1 + carry; the caller seeds carry with 1.
module alu
  import alu_pkg::*;
(
  input  logic       i0,
  input  logic       i1,
  input  logic [1:0] s,
  input  logic       cIn,
  output logic       res,
  output logic       cOut
);

  logic b_eff;

  // Combinational full adder / logic function selected by s
  always_comb begin
    b_eff = (s == OP_SUB) ? ~i1 : i1;
    res   = 1'b0;
    cOut  = 1'b0;
    case (s)
      OP_ADD, OP_SUB: begin
        res  = i0 ^ b_eff ^ cIn;
        cOut = (i0 & b_eff) | (i0 & cIn) | (b_eff & cIn);
      end
      OP_AND: begin
        res  = i0 & i1;
        cOut = 1'b0;
      end
      OP_OR: begin
        res  = i0 | i1;
        cOut = 1'b0;
      end
      default: begin
        res  = 1'b0;
        cOut = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/alu_serial_ctrl.sv
// Bit-serial ALU controller: runs one 1-bit alu cell over WIDTH cycles,
// LSB first, to compute ADD/SUB/AND/OR of two WIDTH-bit operands.
// Parameters:
//   WIDTH : operand/result width, 2..32 (default 16)
// Ports:
//   clk   : clock, rising edge
//   rst   : synchronous active-high reset
//   start : request pulse, accepted only in IDLE
//   op_a, op_b, sel : operands and op code, captured on accepted start
//   busy  : high in RUN and DONE
//   done  : one-cycle pulse in DONE
//   res, cout : result and final carry, held until next accepted start
//   zero  : (only with ALU_SERIAL_ZERO_FLAG_EN defined) res == 0
// Optional feature macro: ALU_SERIAL_ZERO_FLAG_EN
module alu_serial_ctrl
  import alu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic [1:0]       sel,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] res,
`ifdef ALU_SERIAL_ZERO_FLAG_EN
  output logic             zero,
`endif
  output logic             cout
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state_r;
  state_t           state_nxt;
  logic [CW-1:0]    cnt_r;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic [1:0]       sel_r;
  logic             carry_r;
  logic [WIDTH-1:0] shift_r;
  logic             cell_res;
  logic             cell_cout;
  logic             last_bit;
  logic [WIDTH-1:0] shift_nxt;

  // Only the low bits address an operand; the extra counter bit never
  // becomes set because the counter stops at WIDTH-1.
  alu u_alu (
    .i0   (a_r[cnt_r[CW-2:0]]),
    .i1   (b_r[cnt_r[CW-2:0]]),
    .s    (sel_r),
    .cIn  (carry_r),
    .res  (cell_res),
    .cOut (cell_cout)
  );

  assign last_bit  = (cnt_r == LAST);
  assign shift_nxt = {cell_res, shift_r[WIDTH-1:1]};

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt;
    end
  end

  // FSM next-state and status outputs
  always_comb begin
    state_nxt = state_r;
    busy      = 1'b0;
    done      = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          state_nxt = ST_RUN;
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      ST_RUN: begin
        busy = 1'b1;
        if (last_bit) begin
          state_nxt = ST_DONE;
        end else begin
          state_nxt = ST_RUN;
        end
      end
      ST_DONE: begin
        busy      = 1'b1;
        done      = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // Operand capture, serial datapath and result registers
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r   <= {CW{1'b0}};
      a_r     <= {WIDTH{1'b0}};
      b_r     <= {WIDTH{1'b0}};
      sel_r   <= OP_ADD;
      carry_r <= 1'b0;
      shift_r <= {WIDTH{1'b0}};
      res     <= {WIDTH{1'b0}};
      cout    <= 1'b0;
`ifdef ALU_SERIAL_ZERO_FLAG_EN
      zero    <= 1'b0;
`endif
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            a_r     <= op_a;
            b_r     <= op_b;
            sel_r   <= sel;
            cnt_r   <= {CW{1'b0}};
            carry_r <= (sel == OP_SUB);
          end
        end
        ST_RUN: begin
          carry_r <= cell_cout;
          shift_r <= shift_nxt;
          if (last_bit) begin
            // The last bit is folded in directly so res is valid in DONE
            res  <= shift_nxt;
            cout <= is_logic_op(sel_r) ? 1'b0 : cell_cout;
`ifdef ALU_SERIAL_ZERO_FLAG_EN
            zero <= (shift_nxt == {WIDTH{1'b0}});
`endif
          end else begin
            cnt_r <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
          end
        end
        ST_DONE: begin
          cnt_r <= cnt_r;
        end
        default: begin
          cnt_r <= {CW{1'b0}};
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_serial_ctrl.sv
// Self-checking bench for alu_serial_ctrl (WIDTH = 16): directed vectors,
// control corner cases and randomized operations against an arithmetic
// reference model.
module tb_alu_serial_ctrl;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] op_a = '0;
  logic [W-1:0] op_b = '0;
  logic [1:0]   sel = 2'b00;
  logic         busy;
  logic         done;
  logic [W-1:0] res;
  logic         cout;
`ifdef ALU_SERIAL_ZERO_FLAG_EN
  logic         zero;
`endif

  int n_checks = 0;
  int n_errors = 0;

  alu_serial_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .op_a  (op_a),
    .op_b  (op_b),
    .sel   (sel),
    .busy  (busy),
    .done  (done),
    .res   (res),
`ifdef ALU_SERIAL_ZERO_FLAG_EN
    .zero  (zero),
`endif
    .cout  (cout)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: {cout, res} from plain arithmetic
  function automatic logic [W:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                       input logic [1:0] s);
    logic [W:0] r;
    case (s)
      2'b00:   r = {1'b0, a} + {1'b0, b};
      2'b01:   r = {1'b0, a} + {1'b0, ~b} + 1;
      2'b10:   r = {1'b0, a & b};
      default: r = {1'b0, a | b};
    endcase
    return r;
  endfunction

  // Called #1 after an edge: presents a request and lets it be accepted
  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic [1:0] s);
    op_a  = a;
    op_b  = b;
    sel   = s;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    op_a  = W'($urandom);
    op_b  = W'($urandom);
    sel   = 2'($urandom);
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (!done && n < W + 6) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  task automatic run_and_check(input string tag, input logic [W-1:0] a,
                               input logic [W-1:0] b, input logic [1:0] s);
    int n;
    logic [W:0] e;
    e = model(a, b, s);
    start_op(a, b, s);
    wait_done(n);
    check_val({tag, "_lat"}, n, W);
    check_val({tag, "_res"}, res, e[W-1:0]);
    check_val({tag, "_cout"}, cout, e[W]);
`ifdef ALU_SERIAL_ZERO_FLAG_EN
    check_val({tag, "_zero"}, zero, (e[W-1:0] == '0));
`endif
    @(posedge clk);
    #1;
    check_val({tag, "_pulse"}, {busy, done}, 2'b00);
  endtask

  initial begin
    int n;
    logic saw_done;
    logic [W:0] e;

    // Reset state
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check_val("rst_state", {busy, done, cout}, 3'b000);
    check_val("rst_res", res, '0);

    // Directed vectors
    run_and_check("add",     16'hff00, 16'h00ab, 2'b00);
    check_val("add_val", res, 16'hffab);
    run_and_check("add_ovf", 16'hffa0, 16'h00ff, 2'b00);
    check_val("add_ovf_c", cout, 1'b1);
    run_and_check("sub_pos", 16'h0005, 16'h0003, 2'b01);
    check_val("sub_pos_val", {cout, res}, {1'b1, 16'h0002});
    run_and_check("sub_neg", 16'h0003, 16'h0005, 2'b01);
    check_val("sub_neg_val", {cout, res}, {1'b0, 16'hfffe});
    run_and_check("and",     16'hffa0, 16'h00ff, 2'b10);
    check_val("and_val", res, 16'h00a0);
    run_and_check("or",      16'hffa0, 16'h00ff, 2'b11);
    check_val("or_val", res, 16'hffff);
    run_and_check("sub_zero", 16'h00ff, 16'h00ff, 2'b01);
    check_val("sub_zero_val", res, 16'h0000);

    // start re-pulsed at RUN cycle 5 is ignored
    e = model(16'h1234, 16'h0f0f, 2'b00);
    start_op(16'h1234, 16'h0f0f, 2'b00);
    repeat (4) @(posedge clk);
    #1;
    op_a = 16'haaaa; op_b = 16'h5555; sel = 2'b11; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(n);
    check_val("ign_lat", n + 5, W);
    check_val("ign_res", {cout, res}, e);
    @(posedge clk);
    #1;

    // Back-to-back: start in DONE ignored, start next IDLE accepted
    e = model(16'h8001, 16'h8001, 2'b00);
    start_op(16'h0101, 16'h0202, 2'b11);
    wait_done(n);
    op_a = 16'h8001; op_b = 16'h8001; sel = 2'b00; start = 1'b1;
    @(posedge clk);
    #1;
    check_val("b2b_done_ign", busy, 1'b0);
    start_op(16'h8001, 16'h8001, 2'b00);
    wait_done(n);
    check_val("b2b_lat", n, W);
    check_val("b2b_res", {cout, res}, e);
    @(posedge clk);
    #1;

    // Reset at RUN cycle 8 aborts with no done
    start_op(16'h7777, 16'h1111, 2'b00);
    repeat (7) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check_val("abort_state", {busy, done, cout}, 3'b000);
    check_val("abort_res", res, '0);
    saw_done = 1'b0;
    repeat (W + 4) begin
      @(posedge clk);
      #1;
      if (done) saw_done = 1'b1;
    end
    check_val("abort_no_done", saw_done, 1'b0);
    run_and_check("after_abort", 16'h7777, 16'h1111, 2'b01);

    // Reset has priority over start
    op_a = 16'h0001; op_b = 16'h0001; sel = 2'b00;
    rst = 1'b1; start = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0; start = 1'b0;
    @(posedge clk);
    #1;
    check_val("rst_prio", busy, 1'b0);

    // Randomized operations
    for (int i = 0; i < 40; i++) begin
      run_and_check("rand", W'($urandom), W'($urandom), 2'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/alu_serial_ctrl.md
ALU_SERIAL_CTRL -- requirements
Module: alu_serial_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 16: operand/result width in bits; legal range 2..32.
REQ-002 SHALL have port clk, input, 1: sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-004 SHALL have port start, input, 1: request pulse; sampled only in IDLE.
REQ-005 SHALL have port op_a, input, WIDTH: operand A, captured on accepted start.
REQ-006 SHALL have port op_b, input, WIDTH: operand B, captured on accepted start.
REQ-007 SHALL have port sel, input, 2: op code, captured on accepted start; 00 ADD, 01 SUB, 10 AND, 11 OR.
REQ-008 SHALL have port busy, output, 1: high in RUN and DONE.
REQ-009 SHALL have port done, output, 1: single-cycle pulse, high in DONE only.
REQ-010 SHALL have port res, output, WIDTH: result register, held until the next accepted start.
REQ-011 SHALL have port cout, output, 1: final carry out, held with res.

Function
REQ-012 SHALL sequence one instance of the existing 1-bit ALU cell alu (i0, i1, s, cIn -> res, cOut) over WIDTH cycles, LSB first.
REQ-013 SHALL implement FSM states IDLE, RUN, DONE; IDLE->RUN on start; RUN->DONE after bit WIDTH-1; DONE->IDLE unconditionally next cycle.
REQ-014 On accepted start SHALL capture op_a, op_b and sel, clear the bit counter, and seed the carry register with 1 for SUB and 0 otherwise.
REQ-015 In RUN, each cycle SHALL present op_a[cnt], op_b[cnt], captured sel and the carry register to the cell, store the cell's cOut into the carry register, and write the cell's res into a shift register filling from MSB.
REQ-016 Bit counter SHALL be $clog2(WIDTH)+1 bits wide and SHALL NOT wrap inside an operation; RUN exits when counter equals WIDTH-1.
REQ-017 On entry to DONE SHALL load res from the shift register and cout from the carry register; cout SHALL be 0 for AND and OR.
REQ-018 Latency: start sampled at edge T SHALL produce done high in the cycle after edge T+WIDTH, i.e. WIDTH+1 cycles start-to-done.
REQ-019 start while busy SHALL be ignored with no effect on captured operands or progress.
REQ-020 start asserted in the DONE cycle SHALL be ignored; start in the following IDLE cycle SHALL be accepted (back-to-back throughput WIDTH+2 cycles).
REQ-021 Operand/sel input changes after acceptance SHALL NOT affect the running operation.

Reset
REQ-022 rst SHALL force state IDLE, counter 0, carry 0, res 0, cout 0, busy 0, done 0 at the next rising edge, including mid-RUN and in DONE; the interrupted operation produces no done.
REQ-023 rst SHALL take priority over start in the same cycle.

Configuration
REQ-024 With macro ALU_SERIAL_ZERO_FLAG_EN defined SHALL add output zero, 1 bit, updated with res, high when res equals 0, reset to 0.
REQ-025 Without ALU_SERIAL_ZERO_FLAG_EN the zero port and its logic SHALL be absent; all other behaviour identical.

Structure
REQ-026 Shared package alu_pkg SHALL hold op-code constants (OP_ADD, OP_SUB, OP_AND, OP_OR) and FSM state encodings.
REQ-027 The 1-bit ALU cell alu SHALL be instantiated as the single sub-module; no other sub-modules.

Verification
REQ-028 ADD: op_a=16'hff00, op_b=16'h00ab, sel=00, start -> done after 17 cycles, res=16'hffab, cout=0.
REQ-029 ADD overflow: op_a=16'hffa0, op_b=16'h00ff, sel=00 -> res=16'h009f, cout=1.
REQ-030 SUB: op_a=16'h0005, op_b=16'h0003, sel=01 -> res=16'h0002, cout=1; op_a=16'h0003, op_b=16'h0005 -> res=16'hfffe, cout=0.
REQ-031 Logic: op_a=16'hffa0, op_b=16'h00ff, sel=10 -> res=16'h00a0, cout=0; sel=11 -> res=16'hffff, cout=0.
REQ-032 Control: start re-pulsed with new operands at cycle 5 of RUN -> ignored, result of first operation unchanged; rst at cycle 8 of RUN -> next cycle busy=0, res=0, no done pulse; subsequent start completes normally.
REQ-033 With ALU_SERIAL_ZERO_FLAG_EN: op_a=16'h00ff, op_b=16'h00ff, sel=01 -> res=16'h0000, zero=1.
